hiss_tx_ser: RTL
================

HISS_TX_SER -- requirements
Module: hiss_tx_ser

Interface
REQ-001 SHALL have parameter DW, default 8: I and Q sample width in bits, range 2..16.
REQ-002 SHALL have parameter WARM, default 4: driver warm-up cycles after enable, range 1..15.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: pclk  input  1  clock; n_p_reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tx_en  input  1: link enable (level).
REQ-005 SHALL have ports sample_i  input  DW  and  sample_q  input  DW: parallel I and Q sample.
REQ-006 SHALL have port sample_valid  input  1: sample offered.
REQ-007 SHALL have port sample_ready  output  1: sample accepted this cycle when sample_valid is also 1.
REQ-008 SHALL have ports hiss_txi  output  1  and  hiss_txq  output  1: serial I and Q lines to the LVDS pad.
REQ-009 SHALL have ports hiss_txien  output  1  and  hiss_txqen  output  1: LVDS driver enables.
REQ-010 SHALL have port busy  output  1: high in any state other than OFF.
REQ-011 SHALL have port tx_frames  output  16: count of completed frames.

Function
REQ-012 SHALL register every output on pclk rising edge.
REQ-013 SHALL implement states OFF, WARMUP, LINKIDLE, START, DATA and PARITY.
REQ-014 OFF: enables=0, lines=0, ready=0; tx_en=1 -> WARMUP.
REQ-015 WARMUP: enables=1, lines=0, ready=0 for WARM cycles -> LINKIDLE; tx_en=0 at any point -> OFF next cycle.
REQ-016 LINKIDLE: enables=1, lines=0, ready=tx_en; valid&ready -> capture sample_i/sample_q, go to START; tx_en=0 -> OFF.
REQ-017 Frame, I and Q lanes in parallel: START one cycle with line=1; DATA DW cycles, MSB first; PARITY one cycle with line = XOR of the DW captured bits (even parity).
REQ-018 Frame length SHALL be exactly DW+2 cycles; the first START cycle SHALL follow the acceptance cycle directly (latency 1).
REQ-019 ready SHALL also be 1 in the PARITY cycle when tx_en=1; valid in that cycle -> capture and START next cycle (back-to-back, no idle gap).
REQ-020 After PARITY without acceptance: tx_en=1 -> LINKIDLE; tx_en=0 -> OFF.
REQ-021 tx_en deasserted in START/DATA/PARITY SHALL NOT truncate the frame; the frame completes, then OFF, enables drop in the OFF cycle.
REQ-022 ready SHALL be 0 in START and DATA; sample_valid while ready=0 SHALL be ignored (the source holds data).
REQ-023 Captured data SHALL be held in a shift register; input changes after capture SHALL NOT affect the frame.
REQ-024 tx_frames SHALL increment by 1 at each PARITY cycle and wrap from 0xFFFF to 0x0000.
REQ-025 hiss_txien and hiss_txqen SHALL always be equal.

Reset
REQ-026 n_p_reset=0 SHALL immediately (asynchronously) force OFF: hiss_txi=0, hiss_txq=0, hiss_txien=0, hiss_txqen=0, sample_ready=0, busy=0, tx_frames=0, shift registers=0.
REQ-027 Reset mid-frame SHALL abandon the frame without completing it and without incrementing tx_frames.
REQ-028 After release with tx_en=1, SHALL be in WARMUP on the first pclk edge and SHALL run the full WARM cycles.

Verification (DW=8, WARM=4)
REQ-029 Bring-up: reset, then tx_en=1 -> enables=1 one cycle later; sample_ready first 1 exactly 5 cycles after tx_en rises; lines=0 throughout.
REQ-030 Single frame: I=0xA5, Q=0x01 -> txi = 1,1,0,1,0,0,1,0,1,0; txq = 1,0,0,0,0,0,0,0,1,1; tx_frames=1.
REQ-031 Back-to-back: valid held with I=0xFF then I=0x00 -> second START immediately after the first PARITY; 20 contiguous frame cycles; txi parity bits 0 and 0.
REQ-032 Graceful stop: tx_en=0 during DATA bit 3 -> frame completes through PARITY; OFF next cycle; enables=0; ready never 1.
REQ-033 Reset mid-frame: n_p_reset=0 during DATA -> all outputs 0 in the same cycle; tx_frames=0; after release with tx_en=1, WARMUP repeats.
REQ-034 Wrap: 65536 frames -> tx_frames=0x0000.

Source files
------------

// File: rtl/hiss_tx_ser.sv
// hiss_tx_ser: HISS serial transmitter, parallel I/Q samples framed onto two LVDS lines
//   pclk, n_p_reset          clock, asynchronous active-low reset
//   tx_en                    link enable level
//   sample_i/sample_q        DW-bit parallel sample, sample_valid / sample_ready handshake
//   hiss_txi/hiss_txq        serial lines (START=1, DW data bits MSB first, even parity)
//   hiss_txien/hiss_txqen    driver enables, busy = not OFF, tx_frames = completed frame count
module hiss_tx_ser #(
    parameter int DW   = 8,
    parameter int WARM = 4
) (
    input  logic          pclk,
    input  logic          n_p_reset,
    input  logic          tx_en,
    input  logic [DW-1:0] sample_i,
    input  logic [DW-1:0] sample_q,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic          hiss_txi,
    output logic          hiss_txq,
    output logic          hiss_txien,
    output logic          hiss_txqen,
    output logic          busy,
    output logic [15:0]   tx_frames
);
    typedef enum logic [2:0] {OFF, WARMUP, LINKIDLE, START, DATA, PARITY} state_t;
    state_t        state;
    logic [DW-1:0] sh_i, sh_q;
    logic          par_i, par_q;
    logic [4:0]    cnt;
    logic          drv_en;
    logic          accept;
    // ready is only ever raised in LINKIDLE and PARITY, so a handshake implies one of those states
    assign accept     = sample_ready & sample_valid;
    assign hiss_txien = drv_en;
    assign hiss_txqen = drv_en;
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state        <= OFF;
            sh_i         <= '0;
            sh_q         <= '0;
            par_i        <= 1'b0;
            par_q        <= 1'b0;
            cnt          <= '0;
            drv_en       <= 1'b0;
            busy         <= 1'b0;
            sample_ready <= 1'b0;
            hiss_txi     <= 1'b0;
            hiss_txq     <= 1'b0;
            tx_frames    <= '0;
        end else begin
            sample_ready <= 1'b0;
            hiss_txi     <= 1'b0;
            hiss_txq     <= 1'b0;
            if (accept) begin
                state    <= START;
                sh_i     <= sample_i;
                sh_q     <= sample_q;
                par_i    <= ^sample_i;
                par_q    <= ^sample_q;
                hiss_txi <= 1'b1;
                hiss_txq <= 1'b1;
            end else begin
                case (state)
                    OFF: begin
                        if (tx_en) begin
                            state  <= WARMUP;
                            cnt    <= '0;
                            drv_en <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    WARMUP: begin
                        if (!tx_en) begin
                            state  <= OFF;
                            drv_en <= 1'b0;
                            busy   <= 1'b0;
                        end else if (cnt == 5'(WARM - 1)) begin
                            state        <= LINKIDLE;
                            sample_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    LINKIDLE: begin
                        if (!tx_en) begin
                            state  <= OFF;
                            drv_en <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            sample_ready <= 1'b1;
                        end
                    end
                    START: begin
                        state    <= DATA;
                        cnt      <= '0;
                        hiss_txi <= sh_i[DW-1];
                        hiss_txq <= sh_q[DW-1];
                        sh_i     <= {sh_i[DW-2:0], 1'b0};
                        sh_q     <= {sh_q[DW-2:0], 1'b0};
                    end
                    DATA: begin
                        // cnt indexes the data bit currently on the line
                        if (cnt == 5'(DW - 1)) begin
                            state        <= PARITY;
                            hiss_txi     <= par_i;
                            hiss_txq     <= par_q;
                            sample_ready <= tx_en;
                            tx_frames    <= tx_frames + 16'd1;
                        end else begin
                            cnt      <= cnt + 5'd1;
                            hiss_txi <= sh_i[DW-1];
                            hiss_txq <= sh_q[DW-1];
                            sh_i     <= {sh_i[DW-2:0], 1'b0};
                            sh_q     <= {sh_q[DW-2:0], 1'b0};
                        end
                    end
                    PARITY: begin
                        if (tx_en) begin
                            state        <= LINKIDLE;
                            sample_ready <= 1'b1;
                        end else begin
                            state  <= OFF;
                            drv_en <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= OFF;
                        drv_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
